// File: rtl/out_channel_pkg.sv
// out_channel_pkg: shared state encoding and default geometry for the output channel.
package out_channel_pkg;

    localparam int DefaultWidth = 12;
    localparam int DefaultDepth = 200;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } chanState_t;

endpackage

// File: rtl/out_channel_ram.sv
// out_channel_ram: one-write, one-read synchronous storage for the output channel.
// Reads return the old contents when the same address is written in the same cycle.
module out_channel_ram
    import out_channel_pkg::*;
#(
    parameter int Width = DefaultWidth,
    parameter int Depth = DefaultDepth,
    parameter int AddrW = $clog2(DefaultDepth)
) (
    input  logic             clock,
    input  logic             i_wrEn,
    input  logic [AddrW-1:0] i_wrAddr,
    input  logic [Width-1:0] i_wrData,
    input  logic [AddrW-1:0] i_rdAddr,
    output logic [Width-1:0] o_rdData
);

    logic [Width-1:0] r_mem [Depth];
    logic [Width-1:0] r_rdData;

    // Write port and registered read port; contents are intentionally never reset.
    always_ff @(posedge clock) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        r_rdData <= r_mem[i_rdAddr];
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/out_channel.sv
// out_channel: circular output buffer between the core's "out" instructions and a consumer.
// Optional feature macro OUT_CHANNEL_OVERWRITE_EN: when defined, a push into a full buffer
// overwrites the oldest word instead of being refused.
// The oldest word is presented from registers: either a bypass register (when the word was
// pushed in the same cycle it became oldest) or the RAM's registered read, which is always
// addressed with the head pointer of the coming cycle.
module out_channel
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DefaultWidth,
    parameter int NOut               = DefaultDepth
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_valid,
    input  logic [MemoryElementWidth-1:0] push_data,
    output logic                          push_ready,
    input  logic                          flush,
    output logic                          pop_valid,
    output logic [MemoryElementWidth-1:0] pop_data,
    input  logic                          pop_ready,
    output logic [$clog2(NOut+1)-1:0]     count,
    output logic                          overflow,
    output logic                          done
);

    localparam int PtrW = $clog2(NOut);
    localparam int CntW = $clog2(NOut + 1);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(NOut - 1);
    localparam logic [CntW-1:0] FullCount = CntW'(NOut);

    chanState_t r_state, w_stateNext;

    logic [PtrW-1:0] r_head, r_tail;
    logic [PtrW-1:0] w_headInc, w_tailInc, w_headNext, w_tailNext;
    logic [CntW-1:0] r_count, w_countNext;
    logic            r_overflow;
    logic            r_popValid;
    logic            r_useBypass;
    logic [MemoryElementWidth-1:0] r_bypassData;
    logic [MemoryElementWidth-1:0] w_ramData;

    logic w_full, w_empty;
    logic w_popFire, w_pushReady, w_pushFire;
    logic w_dropOldest, w_refused, w_collision;

    // Handshake decode: which side moves this cycle and whether a push evicts the oldest word.
    always_comb begin
        w_full    = (r_count == FullCount);
        w_empty   = (r_count == '0);
        w_popFire = r_popValid && pop_ready;
`ifdef OUT_CHANNEL_OVERWRITE_EN
        w_pushReady = (r_state == RUN);
`else
        w_pushReady = (r_state == RUN) && (!w_full || w_popFire);
`endif
        w_pushFire   = push_valid && w_pushReady;
        w_dropOldest = w_pushFire && w_full && !w_popFire;
        w_refused    = (r_state == RUN) && push_valid && !w_pushReady;
    end

    // Next pointers and occupancy; a collision means the word pushed now becomes the oldest.
    always_comb begin
        w_headInc   = (r_head == LastPtr) ? '0 : r_head + PtrW'(1);
        w_tailInc   = (r_tail == LastPtr) ? '0 : r_tail + PtrW'(1);
        w_headNext  = (w_popFire || w_dropOldest) ? w_headInc : r_head;
        w_tailNext  = w_pushFire ? w_tailInc : r_tail;
        w_countNext = r_count;
        if (w_pushFire && !w_popFire && !w_full) begin
            w_countNext = r_count + CntW'(1);
        end else if (w_popFire && !w_pushFire) begin
            w_countNext = r_count - CntW'(1);
        end
        w_collision = w_pushFire && (w_countNext == CntW'(1));
    end

    // Pointer, occupancy and sticky overflow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= w_headNext;
            r_tail  <= w_tailNext;
            r_count <= w_countNext;
            if (w_refused || w_dropOldest) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output stage: valid flag plus the bypass copy of a word that skipped the RAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_popValid   <= 1'b0;
            r_useBypass  <= 1'b1;
            r_bypassData <= '0;
        end else begin
            r_popValid  <= (w_countNext != '0);
            r_useBypass <= w_collision || (w_countNext == '0);
            if (w_collision) begin
                r_bypassData <= push_data;
            end
        end
    end

    // Channel phase register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Phase transitions: flush stops intake, drained buffer finishes, only reset leaves DONE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            RUN: begin
                if (flush) begin
                    w_stateNext = FLUSH;
                end
            end
            FLUSH: begin
                if (w_empty && !w_pushFire) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = DONE;
            end
            default: begin
                w_stateNext = RUN;
            end
        endcase
    end

    out_channel_ram #(
        .Width (MemoryElementWidth),
        .Depth (NOut),
        .AddrW (PtrW)
    ) u_ram (
        .clock    (clock),
        .i_wrEn   (w_pushFire),
        .i_wrAddr (r_tail),
        .i_wrData (push_data),
        .i_rdAddr (w_headNext),
        .o_rdData (w_ramData)
    );

    assign push_ready = w_pushReady;
    assign pop_valid  = r_popValid;
    assign pop_data   = r_useBypass ? r_bypassData : w_ramData;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign done       = (r_state == DONE);

endmodule

// File: tb/tb_out_channel.sv
// tb_out_channel: randomized and directed stimulus for out_channel, checked against a
// queue-based reference model of the channel's behaviour. Honours OUT_CHANNEL_OVERWRITE_EN.
module tb_out_channel;

    localparam int W = 12;
    localparam int N = 200;
`ifdef OUT_CHANNEL_OVERWRITE_EN
    localparam bit Overwrite = 1'b1;
`else
    localparam bit Overwrite = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset;
    logic                push_valid;
    logic [W-1:0]        push_data;
    logic                push_ready;
    logic                flush;
    logic                pop_valid;
    logic [W-1:0]        pop_data;
    logic                pop_ready;
    logic [$clog2(N+1)-1:0] count;
    logic                overflow;
    logic                done;

    int errors = 0;
    int checks = 0;
    bit monOn  = 1'b0;

    // Reference model state: channel contents in order, plus phase flags.
    int modelQ[$];
    bit mOverflow = 1'b0;
    bit mFlushing = 1'b0;
    bit mDone     = 1'b0;
    int mSize;
    bit mPushOk;

    out_channel #(
        .MemoryElementWidth (W),
        .NOut               (N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .flush      (flush),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .count      (count),
        .overflow   (overflow),
        .done       (done)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    function automatic bit expPushReady();
        if (mFlushing || mDone) return 1'b0;
        if (Overwrite) return 1'b1;
        return (modelQ.size() < N) || (modelQ.size() > 0 && pop_ready);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: applies the channel rules on each clock edge, cleared by reset.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            modelQ.delete();
            mOverflow = 1'b0;
            mFlushing = 1'b0;
            mDone     = 1'b0;
        end else begin
            mSize   = modelQ.size();
            mPushOk = expPushReady();
            if (push_valid && !mPushOk && !mFlushing && !mDone) mOverflow = 1'b1;
            if (mSize > 0 && pop_ready) void'(modelQ.pop_front());
            if (push_valid && mPushOk) begin
                if (modelQ.size() == N) begin
                    void'(modelQ.pop_front());
                    mOverflow = 1'b1;
                end
                modelQ.push_back(int'(push_data));
            end
            if (mFlushing && mSize == 0) begin
                mFlushing = 1'b0;
                mDone     = 1'b1;
            end else if (!mFlushing && !mDone && flush) begin
                mFlushing = 1'b1;
            end
        end
    end

    // Monitor: compares every visible output with the model on the falling edge.
    always @(negedge clock) begin
        if (monOn) begin
            checkOutput("count", int'(count), modelQ.size());
            checkOutput("pop_valid", int'(pop_valid), int'(modelQ.size() != 0));
            checkOutput("push_ready", int'(push_ready), int'(expPushReady()));
            checkOutput("overflow", int'(overflow), int'(mOverflow));
            checkOutput("done", int'(done), int'(mDone));
            if (modelQ.size() > 0) checkOutput("pop_data", int'(pop_data), modelQ[0]);
        end
    end

    task automatic applyStimulus(input logic pv, input int pd, input logic pr, input logic fl);
        push_valid = pv;
        push_data  = W'(pd);
        pop_ready  = pr;
        flush      = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        reset      = 1'b1;
        monOn      = 1'b1;
        #1;
        checkOutput("rstCount", int'(count), 0);
        checkOutput("rstPopValid", int'(pop_valid), 0);
        checkOutput("rstPopData", int'(pop_data), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstPushReady", int'(push_ready), 1);
        checkOutput("rstOverflow", int'(overflow), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Watchdog: a hung run still reports itself.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Test sequence.
    initial begin
        reset      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        @(posedge clock);
        #1;
        applyReset();

        // Three words straight through with the consumer always ready.
        applyStimulus(1'b1, 11, 1'b1, 1'b0);
        applyStimulus(1'b1, 22, 1'b1, 1'b0);
        applyStimulus(1'b1, 33, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("basicDrainCount", int'(count), 0);

        // Fill completely, then offer one more word, then drain.
        for (int i = 0; i < N; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
        checkOutput("fillCount", int'(count), N);
        applyStimulus(1'b1, 500, 1'b0, 1'b0);
        checkOutput("extraPushOverflow", int'(overflow), 1);
        checkOutput("extraPushCount", int'(count), N);
        repeat (N + 2) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("drainEmpty", int'(count), 0);

        // Full buffer with a simultaneous push and pop.
        applyReset();
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1000 + i, 1'b0, 1'b0);
        applyStimulus(1'b1, 777, 1'b1, 1'b0);
        checkOutput("fullPushPopCount", int'(count), N);
        checkOutput("fullPushPopOverflow", int'(overflow), 0);
        repeat (N + 2) applyStimulus(1'b0, 0, 1'b1, 1'b0);

        // Flush with three words buffered.
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 40 + i, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput("flushPushReady", int'(push_ready), 0);
        for (int k = 0; k < 50 && !done; k++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("flushDone", int'(done), 1);
        applyStimulus(1'b1, 99, 1'b1, 1'b0);
        checkOutput("doneIgnoresPush", int'(count), 0);

        // A push coinciding with the flush pulse is kept and drained.
        applyReset();
        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        applyStimulus(1'b1, 6, 1'b0, 1'b1);
        checkOutput("flushPushAccepted", int'(count), 2);
        for (int k = 0; k < 50 && !done; k++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("flushPushDone", int'(done), 1);

        // Reset in the middle of a flush with five words buffered.
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 60 + i, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("preResetCount", int'(count), 5);
        applyReset();

        // Randomized traffic alternating between filling and draining phases.
        for (int c = 0; c < 1800; c++) begin
            int popPct;
            int pushPct;
            popPct  = ((c / 300) % 2 == 0) ? 10 : 90;
            pushPct = ((c / 300) % 2 == 0) ? 90 : 40;
            applyStimulus(1'b1 && ($urandom_range(0, 99) < pushPct),
                          int'($urandom_range(0, (1 << W) - 1)),
                          1'b1 && ($urandom_range(0, 99) < popPct), 1'b0);
        end
        for (int k = 0; k < 2 * N && count != 0; k++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("finalEmpty", int'(count), 0);
        repeat (2) applyStimulus(1'b0, 0, 1'b0, 1'b0);

        monOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
